// File: rtl/sprite_pkg.sv
// Shared constants and the per-axis bounce step for the sprite engine.
package sprite_pkg;

  localparam int R_W          = 3;
  localparam int G_W          = 3;
  localparam int B_W          = 2;
  localparam int COLOR_W      = R_W + G_W + B_W;
  localparam int SCREEN_W_DEF = 800;
  localparam int SCREEN_H_DEF = 600;
  localparam int MAX_SPRITES  = 8;
  localparam int IDX_W        = 3;
  localparam int COORD_W      = 16;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  typedef struct packed {
    logic [COORD_W-1:0] pos;
    dir_e               dir;
  } axis_t;

  function automatic logic [COORD_W-1:0] clamp(
    logic [COORD_W-1:0] p,
    logic [COORD_W-1:0] max
  );
    return (p > max) ? max : p;
  endfunction

  // 17-bit sum so pos+d can never wrap past MAX
  function automatic axis_t axis_step(
    axis_t              cur,
    logic [COORD_W-1:0] d,
    logic [COORD_W-1:0] max
  );
    axis_t        nxt;
    logic [COORD_W:0] sum;
    sum = {1'b0, cur.pos} + {1'b0, d};
    nxt = cur;
    if (cur.dir == DIR_POS) begin
      if (sum >= {1'b0, max}) begin
        nxt.pos = max;
        nxt.dir = DIR_NEG;
      end else begin
        nxt.pos = sum[COORD_W-1:0];
      end
    end else begin
      if (cur.pos <= d) begin
        nxt.pos = '0;
        nxt.dir = DIR_POS;
      end else begin
        nxt.pos = cur.pos - d;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sprite_engine_if.sv
// Sprite load handshake bundle: master drives a load, slave accepts it.
interface sprite_engine_if #(
  parameter int STEP_W = 4
);
  import sprite_pkg::*;

  logic                 i_load_valid;
  logic                 o_load_ready;
  logic [IDX_W-1:0]     i_load_idx;
  logic [COORD_W-1:0]   i_load_x;
  logic [COORD_W-1:0]   i_load_y;
  logic [STEP_W-1:0]    i_load_dx;
  logic [STEP_W-1:0]    i_load_dy;
  logic [COLOR_W-1:0]   i_load_color;

  modport master (
    output i_load_valid, i_load_idx,
    output i_load_x, i_load_y,
    output i_load_dx, i_load_dy,
    output i_load_color,
    input  o_load_ready
  );

  modport slave (
    input  i_load_valid, i_load_idx,
    input  i_load_x, i_load_y,
    input  i_load_dx, i_load_dy,
    input  i_load_color,
    output o_load_ready
  );

endinterface

// File: rtl/sprite_motion.sv
// One sprite: position, direction, step and colour, with load,
// per-frame bounce and the rectangle hit test.
module sprite_motion
  import sprite_pkg::*;
#(
  parameter int                 SPR_W  = 32,
  parameter int                 SPR_H  = 32,
  parameter int                 STEP_W = 4,
  parameter logic [COORD_W-1:0] MAX_X  = 16'd768,
  parameter logic [COORD_W-1:0] MAX_Y  = 16'd568
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               load_we,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic [STEP_W-1:0]  load_dx,
  input  logic [STEP_W-1:0]  load_dy,
  input  logic [COLOR_W-1:0] load_color,
  input  logic [COORD_W-1:0] h,
  input  logic [COORD_W-1:0] v,
  output logic [COLOR_W-1:0] color,
  output logic               hit
);

  axis_t               ax_q;
  axis_t               ay_q;
  logic [STEP_W-1:0]   dx_q;
  logic [STEP_W-1:0]   dy_q;
  logic [COLOR_W-1:0]  color_q;
  logic [COORD_W:0]    x_end;
  logic [COORD_W:0]    y_end;

  // a load in the tick cycle wins and drops this sprite's step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ax_q    <= '{pos: '0, dir: DIR_POS};
      ay_q    <= '{pos: '0, dir: DIR_POS};
      dx_q    <= '0;
      dy_q    <= '0;
      color_q <= '0;
    end else if (load_we) begin
      ax_q    <= '{pos: clamp(load_x, MAX_X), dir: DIR_POS};
      ay_q    <= '{pos: clamp(load_y, MAX_Y), dir: DIR_POS};
      dx_q    <= load_dx;
      dy_q    <= load_dy;
      color_q <= load_color;
    end else if (tick) begin
      ax_q <= axis_step(ax_q, 16'(dx_q), MAX_X);
      ay_q <= axis_step(ay_q, 16'(dy_q), MAX_Y);
    end
  end

  assign x_end = {1'b0, ax_q.pos} + 17'(SPR_W);
  assign y_end = {1'b0, ay_q.pos} + 17'(SPR_H);

  assign hit = (h >= ax_q.pos) && ({1'b0, h} < x_end) &&
               (v >= ay_q.pos) && ({1'b0, v} < y_end);

  assign color = color_q;

endmodule

// File: rtl/sprite_engine.sv
// Multi-sprite RGB332 compositor with per-frame bounce motion.
// Optional collision flag: define SPRITE_ENGINE_COLLISION_EN.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int                 NUM_SPRITES = 4,
  parameter int                 SPR_W       = 32,
  parameter int                 SPR_H       = 32,
  parameter int                 SCREEN_W    = SCREEN_W_DEF,
  parameter int                 SCREEN_H    = SCREEN_H_DEF,
  parameter int                 STEP_W      = 4,
  parameter logic [COLOR_W-1:0] BG_COLOR    = 8'h00
) (
  input  logic               i_pix_clk,
  input  logic               i_reset,
  input  logic [COORD_W-1:0] i_horz_coord,
  input  logic [COORD_W-1:0] i_vert_coord,
  input  logic               i_in_active_area,
  input  logic               i_vert_sync,
  input  logic               i_move_en,
  sprite_engine_if.slave     ld,
  output logic [R_W-1:0]     o_red,
  output logic [G_W-1:0]     o_green,
  output logic [B_W-1:0]     o_blue,
  output logic               o_frame_tick
`ifdef SPRITE_ENGINE_COLLISION_EN
  ,
  output logic               o_collision
`endif
);

  localparam logic [COORD_W-1:0] MAX_X = 16'(SCREEN_W - SPR_W);
  localparam logic [COORD_W-1:0] MAX_Y = 16'(SCREEN_H - SPR_H);

  logic                     vs_q;
  logic                     ready_q;
  logic                     tick;
  logic                     move_tick;
  logic                     load_fire;
  logic [NUM_SPRITES-1:0]   hit;
  logic [COLOR_W-1:0]       spr_color [NUM_SPRITES];
  logic [COLOR_W-1:0]       pix_color;

  assign tick            = i_vert_sync & ~vs_q;
  assign move_tick       = tick & i_move_en;
  assign load_fire       = ld.i_load_valid & ready_q;
  assign ld.o_load_ready = ready_q;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    logic we;
    assign we = load_fire && (ld.i_load_idx == IDX_W'(i));

    sprite_motion #(
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .STEP_W (STEP_W),
      .MAX_X  (MAX_X),
      .MAX_Y  (MAX_Y)
    ) u_mot (
      .clk        (i_pix_clk),
      .rst        (i_reset),
      .tick       (move_tick),
      .load_we    (we),
      .load_x     (ld.i_load_x),
      .load_y     (ld.i_load_y),
      .load_dx    (ld.i_load_dx),
      .load_dy    (ld.i_load_dy),
      .load_color (ld.i_load_color),
      .h          (i_horz_coord),
      .v          (i_vert_coord),
      .color      (spr_color[i]),
      .hit        (hit[i])
    );
  end

  // scan high to low so the lowest hit index wins
  always_comb begin
    pix_color = BG_COLOR;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) pix_color = spr_color[i];
    end
  end

  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      vs_q                     <= 1'b0;
      ready_q                  <= 1'b0;
      o_frame_tick             <= 1'b0;
      {o_red, o_green, o_blue} <= '0;
    end else begin
      vs_q                     <= i_vert_sync;
      ready_q                  <= 1'b1;
      o_frame_tick             <= tick;
      {o_red, o_green, o_blue} <= i_in_active_area ? pix_color : '0;
    end
  end

`ifdef SPRITE_ENGINE_COLLISION_EN
  logic multi_hit;
  logic coll_flag;

  assign multi_hit = $countones(hit) > 1;

  // flag gathers a whole frame, published at the next tick
  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      coll_flag   <= 1'b0;
      o_collision <= 1'b0;
    end else if (tick) begin
      o_collision <= coll_flag;
      coll_flag   <= 1'b0;
    end else if (i_in_active_area && multi_hit) begin
      coll_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: vector table, scoreboard,
// hand sequences for reset, bounce, load-on-tick and collision.
module tb_sprite_engine;

  localparam int         NUM = 4;
  localparam logic [7:0] BG  = 8'h03;
  localparam int         MXX = 768;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] h, v;
  logic        act, vs, men;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        ftick;
`ifdef SPRITE_ENGINE_COLLISION_EN
  logic        coll;
`endif

  sprite_engine_if #(.STEP_W(4)) ld ();

  sprite_engine #(
    .NUM_SPRITES (NUM),
    .BG_COLOR    (BG)
  ) dut (
    .i_pix_clk        (clk),
    .i_reset          (rst),
    .i_horz_coord     (h),
    .i_vert_coord     (v),
    .i_in_active_area (act),
    .i_vert_sync      (vs),
    .i_move_en        (men),
    .ld               (ld),
    .o_red            (red),
    .o_green          (green),
    .o_blue           (blue),
    .o_frame_tick     (ftick)
`ifdef SPRITE_ENGINE_COLLISION_EN
    ,
    .o_collision      (coll)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    int         due;
    logic [7:0] exp;
    string      nm;
  } sb_t;

  sb_t sbq[$];
  sb_t sb_e;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      sb_e = sbq.pop_front();
      chk(sb_e.nm, 32'({red, green, blue}), 32'(sb_e.exp));
    end
  end

  typedef struct {
    string      nm;
    int         h;
    int         v;
    bit         a;
    logic [7:0] e;
  } vec_t;

  vec_t vt[$];

  task automatic pix(string nm, int hh, int vv, bit a, logic [7:0] e);
    @(negedge clk);
    h   = 16'(hh);
    v   = 16'(vv);
    act = a;
    sbq.push_back('{due: cyc + 1, exp: e, nm: nm});
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
    #2;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic set_load(int idx, int x, int y, int dx, int dy,
                          logic [7:0] c);
    ld.i_load_valid = 1'b1;
    ld.i_load_idx   = 3'(idx);
    ld.i_load_x     = 16'(x);
    ld.i_load_y     = 16'(y);
    ld.i_load_dx    = 4'(dx);
    ld.i_load_dy    = 4'(dy);
    ld.i_load_color = c;
  endtask

  task automatic load(int idx, int x, int y, int dx, int dy,
                      logic [7:0] c);
    int k;
    @(negedge clk);
    set_load(idx, x, y, dx, dy, c);
    k = 0;
    while (!ld.o_load_ready && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("load_ready", 32'(ld.o_load_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ld.i_load_valid = 1'b0;
  endtask

  task automatic tick(bit check);
    @(negedge clk);
    act = 1'b0;
    vs  = 1'b1;
    @(posedge clk);
    #1;
    if (check) chk("frame_tick_hi", 32'(ftick), 32'd1);
    @(negedge clk);
    vs = 1'b0;
    @(posedge clk);
    #1;
    if (check) chk("frame_tick_lo", 32'(ftick), 32'd0);
  endtask

  function automatic void mstep(inout int p, inout bit neg,
                                input int d, input int mx);
    if (!neg) begin
      if (p + d >= mx) begin
        p   = mx;
        neg = 1'b1;
      end else begin
        p = p + d;
      end
    end else begin
      if (p <= d) begin
        p   = 0;
        neg = 1'b0;
      end else begin
        p = p - d;
      end
    end
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  px;
    bit  pneg;
    int  guard;

    h   = '0;
    v   = '0;
    act = 1'b0;
    vs  = 1'b0;
    men = 1'b0;
    set_load(0, 0, 0, 0, 0, 8'h00);
    ld.i_load_valid = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_color", 32'({red, green, blue}), 32'd0);
    chk("rst_ready", 32'(ld.o_load_ready), 32'd0);
    chk("rst_ftick", 32'(ftick), 32'd0);
`ifdef SPRITE_ENGINE_COLLISION_EN
    chk("rst_coll", 32'(coll), 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("ready_pre_edge", 32'(ld.o_load_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("ready_post_edge", 32'(ld.o_load_ready), 32'd1);

    // static scene
    load(0, 100, 50, 0, 0, 8'hE0);
    load(1, 200, 200, 0, 0, 8'h1C);
    load(2, 200, 200, 0, 0, 8'h02);
    load(3, 1000, 700, 0, 0, 8'hFF);

    vt.push_back('{"s0_tl",     100,  50, 1'b1, 8'hE0});
    vt.push_back('{"s0_br",     131,  81, 1'b1, 8'hE0});
    vt.push_back('{"s0_right",  132,  50, 1'b1, BG});
    vt.push_back('{"s0_left",    99,  50, 1'b1, BG});
    vt.push_back('{"s0_above",  100,  49, 1'b1, BG});
    vt.push_back('{"s0_below",  100,  82, 1'b1, BG});
    vt.push_back('{"inactive",  100,  50, 1'b0, 8'h00});
    vt.push_back('{"pri12",     200, 200, 1'b1, 8'h1C});
    vt.push_back('{"pri12_br",  231, 231, 1'b1, 8'h1C});
    vt.push_back('{"clamp_x",   768, 568, 1'b1, 8'hFF});
    vt.push_back('{"clamp_xl",  767, 568, 1'b1, BG});
    vt.push_back('{"clamp_ya",  780, 567, 1'b1, BG});
    vt.push_back('{"clamp_br",  799, 599, 1'b1, 8'hFF});
    vt.push_back('{"bg",        500, 500, 1'b1, BG});

    for (int i = 0; i < vt.size(); i++)
      pix(vt[i].nm, vt[i].h, vt[i].v, vt[i].a, vt[i].e);
    drain();

    // priority 0 over 1, then sprite 0 moved away
    load(0, 200, 200, 0, 0, 8'hE0);
    pix("pri01", 200, 200, 1'b1, 8'hE0);
    pix("pri01_br", 231, 231, 1'b1, 8'hE0);
    load(0, 300, 300, 0, 0, 8'hE0);
    pix("pri_moved", 200, 200, 1'b1, 8'h1C);
    pix("s0_new", 300, 300, 1'b1, 8'hE0);
    drain();

    // bounce at MAX then back down to 0
    men = 1'b1;
    load(0, 766, 100, 4, 0, 8'hE0);
    px   = 766;
    pneg = 1'b0;
    tick(1'b1);
    mstep(px, pneg, 4, MXX);
    pix("bmax_l", px - 1, 100, 1'b1, BG);
    pix("bmax",   px,     100, 1'b1, 8'hE0);
    pix("bmax_r", 799,    100, 1'b1, 8'hE0);
    tick(1'b1);
    mstep(px, pneg, 4, MXX);
    pix("bback_l", px - 1,  100, 1'b1, BG);
    pix("bback",   px,      100, 1'b1, 8'hE0);
    pix("bback_r", px + 32, 100, 1'b1, BG);
    guard = 0;
    while (px != 0 && guard < 300) begin
      tick(1'b0);
      mstep(px, pneg, 4, MXX);
      guard++;
    end
    chk("bounce_budget", 32'(px), 32'd0);
    pix("bzero",   0,  100, 1'b1, 8'hE0);
    pix("bzero_r", 31, 100, 1'b1, 8'hE0);
    pix("bzero_o", 32, 100, 1'b1, BG);
    tick(1'b0);
    mstep(px, pneg, 4, MXX);
    pix("bup_l", px - 1, 100, 1'b1, BG);
    pix("bup",   px,     100, 1'b1, 8'hE0);
    drain();

    // move disabled: tick leaves sprites still
    men = 1'b0;
    tick(1'b1);
    pix("hold", px, 100, 1'b1, 8'hE0);
    pix("hold_l", px - 1, 100, 1'b1, BG);
    drain();
    men = 1'b1;

    // load sprite 1 in the tick cycle
    @(negedge clk);
    act = 1'b0;
    vs  = 1'b1;
    set_load(1, 500, 400, 4, 4, 8'h1C);
    @(posedge clk);
    @(negedge clk);
    ld.i_load_valid = 1'b0;
    vs = 1'b0;
    mstep(px, pneg, 4, MXX);
    pix("lt_s1",    500, 400, 1'b1, 8'h1C);
    pix("lt_s1_l",  499, 400, 1'b1, BG);
    pix("lt_s1_a",  500, 399, 1'b1, BG);
    pix("lt_s0",    px,     100, 1'b1, 8'hE0);
    pix("lt_s0_l",  px - 1, 100, 1'b1, BG);
    tick(1'b0);
    mstep(px, pneg, 4, MXX);
    pix("nt_s1",   504, 404, 1'b1, 8'h1C);
    pix("nt_s1_l", 503, 404, 1'b1, BG);
    pix("nt_s0",   px,  100, 1'b1, 8'hE0);
    load(7, 0, 0, 1, 1, 8'hFF);
    pix("idx7_none", 0,   0,   1'b1, BG);
    pix("idx7_s3",   768, 568, 1'b1, 8'hFF);
    pix("idx7_s1",   504, 404, 1'b1, 8'h1C);
    drain();

`ifdef SPRITE_ENGINE_COLLISION_EN
    men = 1'b0;
    tick(1'b0);
    tick(1'b0);
    chk("coll_clear", 32'(coll), 32'd0);
    load(1, 200, 200, 0, 0, 8'h1C);
    pix("coll_pix", 210, 210, 1'b1, 8'h1C);
    drain();
    tick(1'b0);
    chk("coll_set", 32'(coll), 32'd1);
    load(1, 500, 400, 0, 0, 8'h1C);
    pix("sep_pix", 210, 210, 1'b1, 8'h02);
    drain();
    tick(1'b0);
    chk("coll_drop", 32'(coll), 32'd0);
`endif

    // reset in the middle of a line
    pix("pre_rst", 780, 570, 1'b1, 8'hFF);
    drain();
    rst = 1'b1;
    #1;
    chk("mid_rst_color", 32'({red, green, blue}), 32'd0);
    chk("mid_rst_ready", 32'(ld.o_load_ready), 32'd0);
    chk("mid_rst_ftick", 32'(ftick), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_color", 32'({red, green, blue}), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_ready", 32'(ld.o_load_ready), 32'd1);
    chk("rel_bg", 32'({red, green, blue}), 32'(BG));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
